// File: rtl/bsg_fpu_cmp_reduce_if.sv
// Operand stream in, reduced min/max result out, for bsg_fpu_cmp_reduce.
// The producer/consumer side uses the master modport and the reduction engine uses the slave modport.
interface bsg_fpu_cmp_reduce_if #(
  parameter int e_p         = 8,
  parameter int m_p         = 23,
  parameter int cnt_width_p = 16
);
  localparam int w = e_p + m_p + 1;

  logic [w-1:0]           data_i;
  logic                   v_i;
  logic                   last_i;
  logic                   ready_o;
  logic [w-1:0]           min_o;
  logic [w-1:0]           max_o;
  logic                   invalid_o;
  logic [cnt_width_p-1:0] count_o;
  logic                   v_o;
  logic                   yumi_i;

  modport master (
    output data_i, v_i, last_i, yumi_i,
    input  ready_o, min_o, max_o, invalid_o, count_o, v_o
  );

  modport slave (
    input  data_i, v_i, last_i, yumi_i,
    output ready_o, min_o, max_o, invalid_o, count_o, v_o
  );
endinterface

// File: rtl/bsg_fpu_cmp_reduce.sv
// Streaming IEEE-754 min/max reduction.
// Beats are folded one per cycle into running min/max registers. The sNaN (NV) flag and a saturating
// element count are accumulated alongside. The result is held behind a valid/yumi handshake until
// it is consumed.
module bsg_fpu_cmp_reduce #(
  parameter int e_p         = 8,
  parameter int m_p         = 23,
  parameter int cnt_width_p = 16
) (
  input logic                  clk_i,
  input logic                  reset_i,
  bsg_fpu_cmp_reduce_if.slave  io
);

  localparam int w = e_p + m_p + 1;
  localparam logic [w-1:0] canon_nan = {1'b0, {e_p{1'b1}}, 1'b1, {(m_p-1){1'b0}}};

  typedef enum logic [1:0] {eFIRST, eACCUM, eDONE} state_e;

  state_e                 state_reg, state_next;
  logic [w-1:0]           min_reg, min_next;
  logic [w-1:0]           max_reg, max_next;
  logic                   invalid_reg, invalid_next;
  logic [cnt_width_p-1:0] count_reg, count_next;

  logic ready;
  logic xfer;
  assign ready = ~reset_i & (state_reg != eDONE);
  assign xfer  = io.v_i & ready;

  // The incoming beat is classified once; both comparators share the result.
  logic data_nan, data_snan;
  assign data_nan  = (&io.data_i[w-2:m_p]) & (|io.data_i[m_p-1:0]);
  assign data_snan = data_nan & ~io.data_i[m_p-1];

  // Comparator 0 folds the beat into the running minimum, comparator 1 into the running maximum.
  logic [w-1:0] cmp_a   [2];
  logic [w-1:0] cmp_res [2];
  logic         cmp_nv  [2];

  assign cmp_a[0] = min_reg;
  assign cmp_a[1] = max_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cmp
      localparam bit is_min = (gi == 0);
      logic [w-1:0] a, b, a_key, b_key;
      logic         a_nan, a_snan, a_lt_b, pick_a;

      assign a      = cmp_a[gi];
      assign b      = io.data_i;
      assign a_nan  = (&a[w-2:m_p]) & (|a[m_p-1:0]);
      assign a_snan = a_nan & ~a[m_p-1];

      // Map sign-magnitude onto an unsigned total order: negatives invert, positives get the top bit.
      // This puts -0 just below +0.
      assign a_key  = a[w-1] ? ~a : {1'b1, a[w-2:0]};
      assign b_key  = b[w-1] ? ~b : {1'b1, b[w-2:0]};
      assign a_lt_b = a_key < b_key;
      assign pick_a = is_min ? a_lt_b : ~a_lt_b;

      // A lone NaN yields the other operand. Two NaNs yield the canonical NaN.
      assign cmp_res[gi] = (a_nan & data_nan) ? canon_nan :
                           a_nan              ? b :
                           data_nan           ? a :
                           pick_a             ? a : b;
      assign cmp_nv[gi]  = a_snan | data_snan;
    end
  endgenerate

  // Next-state and register updates for the first beat, the accumulation beats and the result-hold phase.
  always_comb begin
    state_next   = state_reg;
    min_next     = min_reg;
    max_next     = max_reg;
    invalid_next = invalid_reg;
    count_next   = count_reg;
    unique case (state_reg)
      eFIRST: begin
        if (xfer) begin
          min_next     = data_nan ? canon_nan : io.data_i;
          max_next     = data_nan ? canon_nan : io.data_i;
          invalid_next = data_snan;
          count_next   = cnt_width_p'(1);
          state_next   = io.last_i ? eDONE : eACCUM;
        end
      end
      eACCUM: begin
        if (xfer) begin
          min_next     = cmp_res[0];
          max_next     = cmp_res[1];
          invalid_next = invalid_reg | cmp_nv[0] | cmp_nv[1];
          count_next   = (&count_reg) ? count_reg : count_reg + cnt_width_p'(1);
          state_next   = io.last_i ? eDONE : eACCUM;
        end
      end
      eDONE: begin
        if (io.yumi_i) state_next = eFIRST;
      end
      default: state_next = eFIRST;
    endcase
  end

  // State and result registers; reset also discards any partially reduced vector.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg   <= eFIRST;
      min_reg     <= canon_nan;
      max_reg     <= canon_nan;
      invalid_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      min_reg     <= min_next;
      max_reg     <= max_next;
      invalid_reg <= invalid_next;
      count_reg   <= count_next;
    end
  end

  // A consumer must only take a result that is actually being presented.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(io.yumi_i && (state_reg != eDONE)))
        else $error("yumi_i asserted while v_o is low");
    end
  end

  assign io.ready_o   = ready;
  assign io.v_o       = (state_reg == eDONE);
  assign io.min_o     = min_reg;
  assign io.max_o     = max_reg;
  assign io.invalid_o = invalid_reg;
  assign io.count_o   = count_reg;

endmodule
